// File: rtl/ex_mem_pipe_if.sv
// EX->MEM stage bus: EX-side entry handshake plus MEM-side registered entry and status.
// The pipe register is the slave; whoever drives EX fields and consumes MEM fields is the master.
interface ex_mem_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int BADDR_W = 7,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16
);
  // EX side
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  readALU;
  logic [DATA_W-1:0]  readWriteData;
  logic [BADDR_W-1:0] readBranchAddress;
  logic [REG_W-1:0]   readRD;
  logic [1:0]         readWB;
  logic [2:0]         readMem;
  logic               readZF;
  logic               readBNE;

  // MEM side
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  aluResult;
  logic [DATA_W-1:0]  writeData;
  logic [BADDR_W-1:0] branchAddress;
  logic [REG_W-1:0]   rd;
  logic [1:0]         wb;
  logic               ZF;
  logic               BNE;
  logic               memRead;
  logic               memWrite;
  logic               branch;
  logic               branchTaken;
  logic [CNT_W-1:0]   stallCount;

  modport slave (
    input  in_valid, readALU, readWriteData, readBranchAddress, readRD, readWB,
           readMem, readZF, readBNE, out_ready,
    output in_ready, out_valid, aluResult, writeData, branchAddress, rd, wb,
           ZF, BNE, memRead, memWrite, branch, branchTaken, stallCount
  );

  modport master (
    output in_valid, readALU, readWriteData, readBranchAddress, readRD, readWB,
           readMem, readZF, readBNE, out_ready,
    input  in_ready, out_valid, aluResult, writeData, branchAddress, rd, wb,
           ZF, BNE, memRead, memWrite, branch, branchTaken, stallCount
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with a skid slot: full-throughput streaming, registered in_ready,
// flush, branch resolution for the head entry and a saturating head-stall counter.
module ex_mem_pipe #(
  parameter int DATA_W  = 32,
  parameter int BADDR_W = 7,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           flush,
  ex_mem_pipe_if.slave   bus
);

  typedef struct packed {
    logic [DATA_W-1:0]  alu;
    logic [DATA_W-1:0]  writeData;
    logic [BADDR_W-1:0] branchAddress;
    logic [REG_W-1:0]   rd;
    logic [1:0]         wb;
    logic [2:0]         mem;   // {branch, memRead, memWrite}
    logic               zf;
    logic               bne;
  } entryT;

  entryT            incoming;
  entryT            mainReg, mainNext;
  entryT            skidReg, skidNext;
  logic             mainValidReg, mainValidNext;
  logic             skidValidReg, skidValidNext;
  logic             inReadyReg;
  logic [CNT_W-1:0] stallCountReg;

  logic accept;
  logic fire;
  logic stallAtMax;

  always_comb begin
    incoming               = '0;
    incoming.alu           = bus.readALU;
    incoming.writeData     = bus.readWriteData;
    incoming.branchAddress = bus.readBranchAddress;
    incoming.rd            = bus.readRD;
    incoming.wb            = bus.readWB;
    incoming.mem           = bus.readMem;
    incoming.zf            = bus.readZF;
    incoming.bne           = bus.readBNE;
  end

  // The flush-cycle input is dropped, so flush also gates acceptance.
  assign accept     = bus.in_valid & inReadyReg & ~flush;
  assign fire       = mainValidReg & bus.out_ready;
  assign stallAtMax = &stallCountReg;

  always_comb begin
    mainNext      = mainReg;
    mainValidNext = mainValidReg;
    skidNext      = skidReg;
    skidValidNext = skidValidReg;
    if (flush) begin
      mainValidNext = 1'b0;
      skidValidNext = 1'b0;
    end else if (fire || !mainValidReg) begin
      if (skidValidReg) begin
        // in_ready was low, so no input can compete with the skid entry here.
        mainNext      = skidReg;
        mainValidNext = 1'b1;
        skidValidNext = 1'b0;
      end else if (accept) begin
        mainNext      = incoming;
        mainValidNext = 1'b1;
      end else begin
        mainValidNext = 1'b0;
      end
    end else if (accept) begin
      skidNext      = incoming;
      skidValidNext = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mainReg       <= '0;
      skidReg       <= '0;
      mainValidReg  <= 1'b0;
      skidValidReg  <= 1'b0;
      inReadyReg    <= 1'b1;
      stallCountReg <= '0;
    end else begin
      mainReg      <= mainNext;
      skidReg      <= skidNext;
      mainValidReg <= mainValidNext;
      skidValidReg <= skidValidNext;
      // Registered copy of the skid-empty flag keeps out_ready off the in_ready path.
      inReadyReg   <= ~skidValidNext;
      if (mainValidReg && !bus.out_ready && !stallAtMax) begin
        stallCountReg <= stallCountReg + CNT_W'(1);
      end
    end
  end

  logic [2:0] memGated;
  logic [1:0] wbGated;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gMemGate
      assign memGated[gi] = mainValidReg & mainReg.mem[gi];
    end
    for (gi = 0; gi < 2; gi++) begin : gWbGate
      assign wbGated[gi] = mainValidReg & mainReg.wb[gi];
    end
  endgenerate

  assign bus.in_ready      = inReadyReg;
  assign bus.out_valid     = mainValidReg;
  assign bus.aluResult     = mainReg.alu;
  assign bus.writeData     = mainReg.writeData;
  assign bus.branchAddress = mainReg.branchAddress;
  assign bus.rd            = mainReg.rd;
  assign bus.wb            = wbGated;
  assign bus.ZF            = mainReg.zf;
  assign bus.BNE           = mainReg.bne;
  assign bus.memWrite      = memGated[0];
  assign bus.memRead       = memGated[1];
  assign bus.branch        = memGated[2];
  assign bus.branchTaken   = memGated[2] & (mainReg.bne ? ~mainReg.zf : mainReg.zf);
  assign bus.stallCount    = stallCountReg;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: directed scenarios followed by random traffic, all checked
// against a queue-based model of the two-entry in-order stage.
module tb_ex_mem_pipe;

  localparam int DW   = 32;
  localparam int BW   = 7;
  localparam int RW   = 5;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] wdata;
    logic [BW-1:0] baddr;
    logic [RW-1:0] rd;
    logic [1:0]    wb;
    logic [2:0]    mem;
    logic          zf;
    logic          bne;
  } entT;

  logic clock = 1'b0;
  logic reset;
  logic flush;

  ex_mem_pipe_if #(.DATA_W(DW), .BADDR_W(BW), .REG_W(RW), .CNT_W(CW)) bus ();

  ex_mem_pipe #(.DATA_W(DW), .BADDR_W(BW), .REG_W(RW), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Model: entries held, in arrival order; data outputs hold the last head once empty.
  entT q[$];
  entT lastHead;
  int  cnt;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelStep();
    entT inE;
    bit  v;
    bit  rdy;
    inE = '{alu: bus.readALU, wdata: bus.readWriteData, baddr: bus.readBranchAddress,
            rd: bus.readRD, wb: bus.readWB, mem: bus.readMem, zf: bus.readZF, bne: bus.readBNE};
    if (reset) begin
      q.delete();
      lastHead = '0;
      cnt      = 0;
    end else begin
      v   = (q.size() > 0);
      rdy = (q.size() < 2);
      if (v && !bus.out_ready && cnt < CMAX) cnt++;
      if (v && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && rdy && !flush) q.push_back(inE);
      if (flush) q.delete();
      if (q.size() > 0) lastHead = q[0];
    end
  endtask

  task automatic checkAll(input string tag);
    entT h;
    bit  v;
    v = (q.size() > 0);
    h = v ? q[0] : lastHead;
    chk({tag, ".out_valid"},     64'(bus.out_valid),     64'(v));
    chk({tag, ".in_ready"},      64'(bus.in_ready),      64'(q.size() < 2));
    chk({tag, ".aluResult"},     64'(bus.aluResult),     64'(h.alu));
    chk({tag, ".writeData"},     64'(bus.writeData),     64'(h.wdata));
    chk({tag, ".branchAddress"}, 64'(bus.branchAddress), 64'(h.baddr));
    chk({tag, ".rd"},            64'(bus.rd),            64'(h.rd));
    chk({tag, ".wb"},            64'(bus.wb),            64'(v ? h.wb : 2'b00));
    chk({tag, ".ZF"},            64'(bus.ZF),            64'(h.zf));
    chk({tag, ".BNE"},           64'(bus.BNE),           64'(h.bne));
    chk({tag, ".memWrite"},      64'(bus.memWrite),      64'(v && h.mem[0]));
    chk({tag, ".memRead"},       64'(bus.memRead),       64'(v && h.mem[1]));
    chk({tag, ".branch"},        64'(bus.branch),        64'(v && h.mem[2]));
    chk({tag, ".branchTaken"},   64'(bus.branchTaken),
        64'(v && h.mem[2] && (h.bne ? !h.zf : h.zf)));
    chk({tag, ".stallCount"},    64'(bus.stallCount),    64'(cnt));
  endtask

  task automatic cycle(input string tag);
    modelStep();
    @(posedge clock);
    #1;
    checkAll(tag);
  endtask

  task automatic setEntry(input logic [31:0] alu, input logic [2:0] mem);
    bus.readALU           = alu;
    bus.readWriteData     = alu ^ 32'h5A5A_0000;
    bus.readBranchAddress = alu[6:0];
    bus.readRD            = alu[4:0];
    bus.readWB            = alu[1:0];
    bus.readMem           = mem;
    bus.readZF            = 1'b0;
    bus.readBNE           = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    setEntry(32'h0, 3'b000);
    lastHead = '0;
    cnt      = 0;

    // Reset state
    cycle("reset");
    chk("reset.in_ready.const", 64'(bus.in_ready), 64'd1);
    chk("reset.out_valid.const", 64'(bus.out_valid), 64'd0);
    reset = 1'b0;
    cycle("idle");

    // Streaming 1,2,3
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      setEntry(32'(k), 3'b010);
      cycle($sformatf("stream%0d", k));
      chk($sformatf("stream%0d.alu.const", k), 64'(bus.aluResult), 64'(k));
      chk($sformatf("stream%0d.in_ready.const", k), 64'(bus.in_ready), 64'd1);
    end

    // Backpressure: A in main, B to skid, C refused
    setEntry(32'hA, 3'b000);
    cycle("bp.loadA");
    bus.out_ready = 1'b0;
    setEntry(32'hB, 3'b000);
    cycle("bp.offerB");
    chk("bp.offerB.in_ready.const", 64'(bus.in_ready), 64'd0);
    chk("bp.offerB.stall.const", 64'(bus.stallCount), 64'd1);
    setEntry(32'hC, 3'b000);
    cycle("bp.offerC");
    chk("bp.offerC.alu.const", 64'(bus.aluResult), 64'hA);
    chk("bp.offerC.stall.const", 64'(bus.stallCount), 64'd2);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    cycle("bp.drainA");
    chk("bp.drainA.alu.const", 64'(bus.aluResult), 64'hB);
    bus.in_valid = 1'b1;
    cycle("bp.reofferC");
    chk("bp.reofferC.alu.const", 64'(bus.aluResult), 64'hC);
    bus.in_valid = 1'b0;
    cycle("bp.empty");

    // Branch resolution
    bus.in_valid = 1'b1;
    setEntry(32'h40, 3'b100);
    bus.readZF  = 1'b1;
    bus.readBNE = 1'b0;
    cycle("br.beqTaken");
    chk("br.beqTaken.const", 64'(bus.branchTaken), 64'd1);
    bus.readBNE = 1'b1;
    cycle("br.bneNotTaken");
    chk("br.bneNotTaken.const", 64'(bus.branchTaken), 64'd0);
    bus.in_valid = 1'b0;
    cycle("br.invalid");
    chk("br.invalid.const", 64'(bus.branchTaken), 64'd0);

    // Flush with both entries held and input offered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    setEntry(32'h11, 3'b001);
    cycle("fl.loadX");
    setEntry(32'h22, 3'b001);
    cycle("fl.loadY");
    flush = 1'b1;
    setEntry(32'h33, 3'b001);
    cycle("fl.flush");
    chk("fl.flush.out_valid.const", 64'(bus.out_valid), 64'd0);
    chk("fl.flush.in_ready.const", 64'(bus.in_ready), 64'd1);
    chk("fl.flush.memWrite.const", 64'(bus.memWrite), 64'd0);
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle("fl.after");
      chk("fl.after.out_valid.const", 64'(bus.out_valid), 64'd0);
    end

    // Stall counter saturation
    reset = 1'b1;
    cycle("sat.reset");
    reset         = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    setEntry(32'h77, 3'b010);
    cycle("sat.load");
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle($sformatf("sat%0d", k));
      chk($sformatf("sat%0d.stall.const", k), 64'(bus.stallCount), 64'(k < CMAX ? k : CMAX));
    end

    // Reset while both entries are held
    bus.in_valid = 1'b1;
    setEntry(32'h88, 3'b111);
    cycle("rb.fillSkid");
    chk("rb.fillSkid.in_ready.const", 64'(bus.in_ready), 64'd0);
    reset = 1'b1;
    cycle("rb.reset");
    chk("rb.reset.out_valid.const", 64'(bus.out_valid), 64'd0);
    chk("rb.reset.in_ready.const", 64'(bus.in_ready), 64'd1);
    chk("rb.reset.alu.const", 64'(bus.aluResult), 64'd0);
    chk("rb.reset.stall.const", 64'(bus.stallCount), 64'd0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    cycle("rb.idle");

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      bus.in_valid          = ($urandom_range(0, 3) != 0);
      bus.out_ready         = ($urandom_range(0, 4) >= 2);
      flush                 = ($urandom_range(0, 19) == 0);
      reset                 = ($urandom_range(0, 99) == 0);
      bus.readALU           = $urandom;
      bus.readWriteData     = $urandom;
      bus.readBranchAddress = 7'($urandom);
      bus.readRD            = 5'($urandom);
      bus.readWB            = 2'($urandom_range(0, 3));
      bus.readMem           = 3'($urandom_range(0, 7));
      bus.readZF            = 1'($urandom_range(0, 1));
      bus.readBNE           = 1'($urandom_range(0, 1));
      cycle($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
